// File: rtl/gf_add_scheduler.sv
// gf_add_scheduler
//   Round-robin front end for a shared WIDTH-bit adder. Two requesters submit
//   operand pairs tagged with a mode bit. GF mode gives a carry-less sum
//   (a ^ b, carry 0). Integer mode gives {carry, sum} = a + b.
//   One operation is in flight at a time: IDLE (grant) -> EXEC (compute)
//   -> RESP (hold result until accepted).
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   reqN_valid/ready         request handshake per requester (N = 0, 1)
//   reqN_a, reqN_b, reqN_gf  operands and mode (1 = GF/XOR, 0 = integer)
//   rsp_valid/ready          result handshake
//   rsp_sum, rsp_carry       result value and integer carry-out
//   rsp_id, rsp_gf           issuing requester and mode of the result
//   busy                     high whenever the FSM is not in IDLE
module gf_add_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_gf,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_gf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_id,
  output logic             rsp_gf,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_gf_q, op_gf_d;
  logic             op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_gf_q, rsp_gf_d;

  logic             grant0;
  logic             grant1;
  logic [WIDTH:0]   int_sum;

  // Full-width integer sum so the carry-out is never truncated.
  assign int_sum = {1'b0, op_a_q} + {1'b0, op_b_q};

  // Round-robin grant, only offered in IDLE. Gated by rst so the readies
  // drop to 0 the moment reset is asserted, without waiting for a clock.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        // Tie: the requester that did not win last time goes first.
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Next-state, operand capture and result computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_gf_d      = op_gf_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    rsp_gf_d     = rsp_gf_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 && req0_valid) begin
          op_a_d       = req0_a;
          op_b_d       = req0_b;
          op_gf_d      = req0_gf;
          op_id_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (grant1 && req1_valid) begin
          op_a_d       = req1_a;
          op_b_d       = req1_b;
          op_gf_d      = req1_gf;
          op_id_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (op_gf_q) begin
          rsp_sum_d   = op_a_q ^ op_b_q;
          rsp_carry_d = 1'b0;
        end else begin
          rsp_sum_d   = int_sum[WIDTH-1:0];
          rsp_carry_d = int_sum[WIDTH];
        end
        rsp_id_d    = op_id_q;
        rsp_gf_d    = op_gf_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Returning to IDLE here means the next grant can only be offered
        // in the following cycle; rsp_ready never reaches the readies.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= {WIDTH{1'b0}};
      op_b_q       <= {WIDTH{1'b0}};
      op_gf_q      <= 1'b0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= {WIDTH{1'b0}};
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_gf_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_gf_q      <= op_gf_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
      rsp_gf_q     <= rsp_gf_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_gf     = rsp_gf_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gf_add_scheduler.sv
// tb_gf_add_scheduler
//   Directed, self-checking bench for gf_add_scheduler. Inputs change 2 time
//   units after a rising edge; outputs are checked 1 unit after that.
module tb_gf_add_scheduler;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_gf;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_gf;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_carry, rsp_id, rsp_gf, busy;

  int errors = 0;
  int checks = 0;

  gf_add_scheduler #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_gf(req0_gf),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_gf(req1_gf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
    .rsp_gf(rsp_gf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_sum"}, rsp_sum, 0);
    check({tag, "_rsp_carry"}, rsp_carry, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_gf"}, rsp_gf, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
  endtask

  // Single-requester operation with rsp_ready high; checks grant pulse,
  // EXEC cycle, response contents and return to IDLE.
  task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic gf,
                        input logic [31:0] esum, input logic ecarry);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_gf = gf;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_gf = gf;
    end
    #1;
    check({tag, "_rdy0"}, req0_ready, !id);
    check({tag, "_rdy1"}, req1_ready, id);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check({tag, "_exec_rdy"}, {req0_ready, req1_ready}, 0);
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_valid"}, rsp_valid, 0);
    tick();
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_sum"}, rsp_sum, esum);
    check({tag, "_carry"}, rsp_carry, ecarry);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_gf"}, rsp_gf, gf);
    tick();
    check({tag, "_done_valid"}, rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_gf = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_gf = 1'b0;
    rsp_ready = 1'b0;
    #2;
    check_idle_outputs("in_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    check_idle_outputs("after_reset");

    // Basic GF and integer operations, including carry-out.
    run_op("gf0", 1'b0, 32'd10, 32'd25, 1'b1, 32'h13, 1'b0);
    run_op("int1", 1'b1, 32'd10, 32'd25, 1'b0, 32'd35, 1'b0);
    run_op("carry1", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1);

    // Fairness: both valid continuously; last grant was 1 so 0 goes first.
    req0_a = 32'd28; req0_b = 32'd72; req0_gf = 1'b1;
    req1_a = 32'd28; req1_b = 32'd72; req1_gf = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic eid;
      eid = k[0];
      #1;
      check("rr_rdy0", req0_ready, !eid);
      check("rr_rdy1", req1_ready, eid);
      check("rr_onehot", req0_ready & req1_ready, 0);
      tick();
      check("rr_exec_rdy", {req0_ready, req1_ready}, 0);
      tick();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, eid);
      check("rr_sum", rsp_sum, eid ? 32'd100 : 32'h54);
      check("rr_gf", rsp_gf, !eid);
      check("rr_resp_rdy", {req0_ready, req1_ready}, 0);
      tick();
    end

    // Backpressure: grant to 0 (last was 1), then stall 5 cycles in RESP.
    rsp_ready = 1'b0;
    #1;
    check("bp_rdy0", req0_ready, 1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, 32'h54);
      check("bp_id", rsp_id, 0);
      check("bp_gf", rsp_gf, 1);
      check("bp_carry", rsp_carry, 0);
      check("bp_busy", busy, 1);
      check("bp_rdy", {req0_ready, req1_ready}, 0);
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", rsp_valid, 0);
    check("bp_next_rdy1", req1_ready, 1);
    check("bp_next_rdy0", req0_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("bp_withdraw_busy", busy, 0);

    // Reset during EXEC (last grant becomes 0 before reset).
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd25; req0_gf = 1'b1;
    tick();
    req0_valid = 1'b0;
    #1;
    check("rx_exec_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rx_async");
    tick();
    rst = 1'b0;
    tick();
    check("rx_stale1", rsp_valid, 0);
    tick();
    check("rx_stale2", rsp_valid, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rx_tie_rdy0", req0_ready, 1);
    check("rx_tie_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("rx_withdraw_busy", busy, 0);

    // Reset during RESP with a non-zero, id=1 result held.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd25; req1_gf = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    check("rr2_valid", rsp_valid, 1);
    check("rr2_sum", rsp_sum, 32'h13);
    check("rr2_id", rsp_id, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rr2_async");
    tick();
    rst = 1'b0;
    tick();
    check("rr2_stale1", rsp_valid, 0);
    tick();
    check("rr2_stale2", rsp_valid, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rr2_tie_rdy0", req0_ready, 1);
    check("rr2_tie_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Request pulsed and withdrawn while the FSM sits in RESP.
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_gf = 1'b0;
    tick();
    req1_valid = 1'b0;
    tick();
    check("wd_valid", rsp_valid, 1);
    check("wd_sum", rsp_sum, 32'd3);
    req0_valid = 1'b1;
    #1;
    check("wd_resp_rdy", {req0_ready, req1_ready}, 0);
    tick();
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("wd_still_valid", rsp_valid, 1);
    tick();
    check("wd_idle_valid", rsp_valid, 0);
    check("wd_idle_busy", busy, 0);
    check("wd_idle_rdy0", req0_ready, 0);
    tick();
    check("wd_no_grant_busy", busy, 0);
    check("wd_no_rsp1", rsp_valid, 0);
    tick();
    check("wd_no_rsp2", rsp_valid, 0);
    check("wd_no_busy2", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
